ppu_vram_oam_arbiter: RTL and testbench
=======================================

Name: ppu_vram_oam_arbiter

Overview:
- Owns the single shared VRAM/OAM memory port (0x8000-0x9FFF and 0xFE00-0xFE9F). Sequences OAM DMA and arbitrates between DMA, PPU fetch and CPU.
- Applies the DMG mode-based access locks: VRAM is locked in DRAW; OAM is locked in SCAN, in DRAW and while DMA is active.
- Sits between the CPU MMIO bus, the PPU fetch port and the VRAM/OAM RAM. DMA sources outside VRAM are read over a separate system-bus port.

Parameters:
- CYCLES_PER_BYTE, 4, clocks per DMA byte slot (minimum 3).
- OAM_BYTES, 160, number of bytes copied per DMA.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  16  CPU address
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, valid the cycle after cpu_rd
- ppu_mode  in  2  PPU mode: 0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW
- ppu_rd  in  1  PPU fetch strobe
- ppu_addr  in  16  PPU fetch address
- ppu_rdata  out  8  PPU read data, valid the cycle after ppu_rd
- mem_addr  out  16  shared RAM address
- mem_rd  out  1  shared RAM read
- mem_wr  out  1  shared RAM write
- mem_wdata  out  8  shared RAM write data
- mem_rdata  in  8  shared RAM data, valid one clock after mem_rd
- sys_addr  out  16  DMA source address, non-VRAM
- sys_rd  out  1  DMA source read
- sys_rdata  in  8  system read data, valid one clock after sys_rd
- dma_active  out  1  DMA in progress, setup cycle included

Behaviour:
- Reset: all outputs 0 except cpu_rdata=0xFF and ppu_rdata=0xFF. DMA FSM returns to IDLE. Reset aborts an in-flight DMA immediately.
- Address classes:
  - VRAM = 0x8000-0x9FFF.
  - OAM = 0xFE00-0xFE9F.
  - CPU accesses outside these ranges, except 0xFF46, are ignored. For ignored reads, cpu_rdata = 0xFF.
- DMA trigger: cpu_wr with cpu_addr==0xFF46 latches page P = cpu_wdata.
  - Source page is P-0x20 when P >= 0xE0; otherwise P.
- DMA FSM states: IDLE -> SETUP (1 clk) -> XFER -> IDLE.
  - In XFER, byte i (0..OAM_BYTES-1) occupies one slot of CYCLES_PER_BYTE clocks.
  - Slot clk0: issue source read at {page, i}. Use mem_rd if the source is in VRAM (page 0x80-0x9F); otherwise use sys_rd.
  - Slot clk1: capture the returned data.
  - Slot clk2: mem_wr to 0xFE00+i with the captured data.
  - Remaining clocks are idle.
  - After byte OAM_BYTES-1 completes, return to IDLE.
  - Total busy time = 1 + OAM_BYTES*CYCLES_PER_BYTE clocks (641 with defaults).
- dma_active is high in SETUP and XFER.
- A 0xFF46 write during SETUP/XFER restarts: new page is latched, FSM enters SETUP, i=0, and the in-flight byte is discarded (no OAM write).
- Port priority per clock:
  1. DMA (in its slot clocks that use mem).
  2. PPU.
  3. CPU.
- At most one mem_rd/mem_wr per clock.
- PPU rules:
  - A PPU read targeting OAM while dma_active is denied; ppu_rdata = 0xFF next clk.
  - A PPU read that loses mem to DMA (VRAM-source slot clk0) returns 0xFF.
  - Otherwise ppu_rdata = mem_rdata next clk.
- CPU lock rules:
  - A VRAM access is blocked when ppu_mode==3.
  - An OAM access is blocked when ppu_mode is 2 or 3, or dma_active.
  - Any access is blocked when it loses mem to DMA or the PPU in that clock.
  - A blocked read returns 0xFF next clk; a blocked write is dropped silently (no stall).
- Read return routing uses a 1-clk registered grant tag {none, cpu, ppu, dma}. Data goes only to the owner of the previous clock's mem_rd. The other rdata output holds 0xFF when it has no grant.
- Simultaneous events:
  - A CPU 0xFF46 write in the same clk as a DMA byte write: the byte write completes and the restart takes effect next clk.
  - cpu_rd and cpu_wr both high: treat as write.
- mem_wdata is 0 when mem_wr is low.

Test Plan:
- Idle, ppu_mode=0, CPU write 0x5A to 0x8010, then read 0x8010 -> mem_wr at 0x8010/0x5A; cpu_rdata=0x5A one clk after the read.
- ppu_mode=3, CPU read 0x9800 and write to 0xFE00 -> cpu_rdata=0xFF; no mem_wr issued; PPU reads are unaffected.
- CPU write 0xC1 to 0xFF46 -> dma_active high for exactly 641 clks.
  - sys_rd at 0xC100..0xC19F.
  - mem_wr at 0xFE00..0xFE9F with the returned data, one byte every 4 clks.
- Same as the previous scenario with page 0x80 -> source reads on mem_rd at 0x8000+i. A PPU fetch colliding with slot clk0 gets 0xFF.
- Write 0xC1 to 0xFF46, then 0xD2 at byte 50 -> the in-flight byte is not written; restart from 0xD200. OAM ends with the D2 page; dma_active stays high for 641 clks after the second write.
- Assert rst at byte 10 of a DMA -> next clk dma_active=0, mem_wr=0; no further OAM writes.

Source files
------------

// File: rtl/ppu_vram_oam_arbiter.sv
// Owner of the shared VRAM/OAM memory port: sequences OAM DMA and arbitrates
// DMA > PPU > CPU each clock, applying the DMG mode-based CPU access locks.
module ppu_vram_oam_arbiter #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int OAM_BYTES       = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic [1:0]  ppu_mode,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] sys_addr,
  output logic        sys_rd,
  input  logic [7:0]  sys_rdata,
  output logic        dma_active,
  output logic [1:0]  dbg_dma_state
);

  // Handshake semantics: cpu_rd/cpu_wr/ppu_rd are single-clock strobes that are
  // never stalled. A strobe is either granted in the clock it is seen or dropped;
  // read data always comes back exactly one clock later, 0xFF when not granted.

  localparam int SW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_CPU  = 2'd1;
  localparam logic [1:0] TAG_PPU  = 2'd2;
  localparam logic [1:0] TAG_DMA  = 2'd3;

  localparam logic [SW-1:0] SLOT_READ    = SW'(0);
  localparam logic [SW-1:0] SLOT_CAPTURE = SW'(1);
  localparam logic [SW-1:0] SLOT_WRITE   = SW'(2);
  localparam logic [SW-1:0] SLOT_LAST    = SW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    BYTE_LAST    = 8'(OAM_BYTES - 1);

  logic [1:0]    state;
  logic [SW-1:0] slot;
  logic [7:0]    idx;
  logic [7:0]    src_page;
  logic [7:0]    dma_data;
  logic [1:0]    rd_tag;

  function automatic logic in_vram(input logic [15:0] a);
    return a[15:13] == 3'b100;
  endfunction

  function automatic logic in_oam(input logic [15:0] a);
    return (a[15:8] == 8'hFE) && (a[7:0] < 8'hA0);
  endfunction

  logic dma_busy;
  logic in_xfer;
  logic src_vram;
  logic dma_mem_rd;
  logic dma_sys_rd;
  logic dma_wr;
  logic dma_owns_mem;
  logic ppu_grant;
  logic cpu_vram;
  logic cpu_oam;
  logic cpu_locked;
  logic cpu_grant;
  logic cpu_rd_op;
  logic dma_trigger;

  assign dma_busy     = (state != S_IDLE);
  assign in_xfer      = (state == S_XFER);
  assign src_vram     = (src_page[7:5] == 3'b100);
  assign dma_mem_rd   = in_xfer && (slot == SLOT_READ) && src_vram;
  assign dma_sys_rd   = in_xfer && (slot == SLOT_READ) && !src_vram;
  assign dma_wr       = in_xfer && (slot == SLOT_WRITE);
  assign dma_owns_mem = dma_mem_rd || dma_wr;

  // OAM is invisible to the PPU for the whole DMA, not only in DMA's own clocks.
  assign ppu_grant = ppu_rd && !(in_oam(ppu_addr) && dma_busy) && !dma_owns_mem;

  assign cpu_vram    = in_vram(cpu_addr);
  assign cpu_oam     = in_oam(cpu_addr);
  assign cpu_rd_op   = cpu_rd && !cpu_wr;
  assign cpu_locked  = (cpu_vram && (ppu_mode == 2'd3)) ||
                       (cpu_oam && (ppu_mode[1] || dma_busy));
  assign cpu_grant   = (cpu_wr || cpu_rd) && (cpu_vram || cpu_oam) && !cpu_locked &&
                       !dma_owns_mem && !ppu_grant;
  assign dma_trigger = cpu_wr && (cpu_addr == 16'hFF46);

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    sys_rd    = 1'b0;
    sys_addr  = 16'h0000;
    if (dma_mem_rd) begin
      mem_rd   = 1'b1;
      mem_addr = {src_page, idx};
    end else if (dma_wr) begin
      mem_wr    = 1'b1;
      mem_addr  = {8'hFE, idx};
      mem_wdata = dma_data;
    end else if (ppu_grant) begin
      mem_rd   = 1'b1;
      mem_addr = ppu_addr;
    end else if (cpu_grant) begin
      mem_addr = cpu_addr;
      if (cpu_wr) begin
        mem_wr    = 1'b1;
        mem_wdata = cpu_wdata;
      end else begin
        mem_rd = 1'b1;
      end
    end
    if (dma_sys_rd) begin
      sys_rd   = 1'b1;
      sys_addr = {src_page, idx};
    end
    if (rst) begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 8'h00;
      sys_rd    = 1'b0;
      sys_addr  = 16'h0000;
    end
  end

  assign cpu_rdata     = (!rst && (rd_tag == TAG_CPU)) ? mem_rdata : 8'hFF;
  assign ppu_rdata     = (!rst && (rd_tag == TAG_PPU)) ? mem_rdata : 8'hFF;
  assign dma_active    = !rst && dma_busy;
  assign dbg_dma_state = rst ? S_IDLE : state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      slot     <= '0;
      idx      <= 8'h00;
      src_page <= 8'h00;
      dma_data <= 8'h00;
      rd_tag   <= TAG_NONE;
    end else begin
      if (dma_mem_rd)
        rd_tag <= TAG_DMA;
      else if (ppu_grant)
        rd_tag <= TAG_PPU;
      else if (cpu_grant && cpu_rd_op)
        rd_tag <= TAG_CPU;
      else
        rd_tag <= TAG_NONE;

      if (in_xfer && (slot == SLOT_CAPTURE))
        dma_data <= src_vram ? mem_rdata : sys_rdata;

      // A retrigger wins over sequencing; a byte write issued this clock still lands.
      if (dma_trigger) begin
        src_page <= (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;
        state    <= S_SETUP;
        slot     <= '0;
        idx      <= 8'h00;
      end else begin
        case (state)
          S_SETUP: begin
            state <= S_XFER;
            slot  <= '0;
            idx   <= 8'h00;
          end
          S_XFER: begin
            if (slot == SLOT_LAST) begin
              slot <= '0;
              if (idx == BYTE_LAST)
                state <= S_IDLE;
              else
                idx <= idx + 8'd1;
            end else begin
              slot <= slot + SW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppu_vram_oam_arbiter.sv
// Randomized bench for ppu_vram_oam_arbiter: per-clock reference model of the
// access rules and a DMA schedule derived from the trigger time.
module tb_ppu_vram_oam_arbiter;

  localparam int CPB    = 4;
  localparam int NBYTES = 160;
  localparam int BUSY   = 1 + NBYTES * CPB;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [1:0]  ppu_mode;
  logic        ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] sys_addr;
  logic        sys_rd;
  logic [7:0]  sys_rdata;
  logic        dma_active;
  logic [1:0]  dbg_dma_state;

  ppu_vram_oam_arbiter #(.CYCLES_PER_BYTE(CPB), .OAM_BYTES(NBYTES)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .ppu_mode(ppu_mode), .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .sys_addr(sys_addr), .sys_rd(sys_rd), .sys_rdata(sys_rdata),
    .dma_active(dma_active), .dbg_dma_state(dbg_dma_state)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    logic [15:0] t;
    t = (a * 16'd73) ^ (a >> 7);
    return t[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sys_byte(input logic [15:0] a);
    logic [15:0] t;
    t = (a * 16'd151) + (a >> 4);
    return t[7:0] ^ 8'hC3;
  endfunction

  function automatic logic is_vram(input logic [15:0] a);
    return (a >= 16'h8000) && (a <= 16'h9FFF);
  endfunction

  function automatic logic is_oam(input logic [15:0] a);
    return (a >= 16'hFE00) && (a <= 16'hFE9F);
  endfunction

  // shared RAM and system bus: data one clock after the strobe
  logic [7:0] ram [0:65535];
  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = init_byte(16'(a));
    mem_rdata = 8'h00;
    sys_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_rd) mem_rdata <= ram[mem_addr];
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      if (sys_rd) sys_rdata <= sys_byte(sys_addr);
    end
  end

  // scoreboard / reference model state
  logic [7:0]  model_mem [0:65535];
  logic [23:0] exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          dma_t0  = 0;
  logic        dma_on  = 1'b0;
  logic [7:0]  dma_page = 8'h00;
  logic [7:0]  exp_cpu = 8'hFF;
  logic [7:0]  exp_ppu = 8'hFF;

  logic        s_rst, s_c_rd, s_c_wr, s_p_rd;
  logic [15:0] s_c_addr, s_p_addr;
  logic [7:0]  s_c_wdata;
  logic [1:0]  s_mode;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // one clock: drive staged inputs, check outputs, advance the model
  task automatic tick();
    int rel, off, bi, k;
    logic act, d_vram, d_mrd, d_srd, d_wr, d_mem, p_grant, c_w, c_r, c_lock, c_grant;
    logic e_rd, e_wr;
    logic [15:0] e_addr, src_a;
    logic [7:0] e_wdata, src_byte;
    logic [23:0] q_item;
    @(negedge clk);
    rst = s_rst; cpu_rd = s_c_rd; cpu_wr = s_c_wr; cpu_addr = s_c_addr;
    cpu_wdata = s_c_wdata; ppu_mode = s_mode; ppu_rd = s_p_rd; ppu_addr = s_p_addr;
    #1;
    if (s_rst) begin
      chk("rst_mem_rd", 24'(mem_rd), 24'd0);
      chk("rst_mem_wr", 24'(mem_wr), 24'd0);
      chk("rst_mem_addr", 24'(mem_addr), 24'd0);
      chk("rst_mem_wdata", 24'(mem_wdata), 24'd0);
      chk("rst_sys_rd", 24'(sys_rd), 24'd0);
      chk("rst_sys_addr", 24'(sys_addr), 24'd0);
      chk("rst_dma_active", 24'(dma_active), 24'd0);
      chk("rst_dbg_state", 24'(dbg_dma_state), 24'd0);
      chk("rst_cpu_rdata", 24'(cpu_rdata), 24'hFF);
      chk("rst_ppu_rdata", 24'(ppu_rdata), 24'hFF);
      dma_on = 1'b0;
      exp_q.delete();
      exp_cpu = 8'hFF;
      exp_ppu = 8'hFF;
    end else begin
      rel = cyc - dma_t0;
      act = dma_on && (rel >= 1) && (rel <= BUSY);
      bi = 0;
      k = -1;
      if (act && rel >= 2) begin
        off = rel - 2;
        bi  = off / CPB;
        k   = off % CPB;
      end
      src_a   = {dma_page, 8'(bi)};
      d_vram  = (dma_page >= 8'h80) && (dma_page <= 8'h9F);
      d_mrd   = (k == 0) && d_vram;
      d_srd   = (k == 0) && !d_vram;
      d_wr    = (k == 2);
      d_mem   = d_mrd || d_wr;
      p_grant = s_p_rd && !(is_oam(s_p_addr) && act) && !d_mem;
      c_w     = s_c_wr;
      c_r     = s_c_rd && !s_c_wr;
      c_lock  = (is_vram(s_c_addr) && s_mode == 2'd3) ||
                (is_oam(s_c_addr) && (s_mode >= 2'd2 || act));
      c_grant = (c_w || c_r) && (is_vram(s_c_addr) || is_oam(s_c_addr)) &&
                !c_lock && !d_mem && !p_grant;
      e_rd = 1'b0; e_wr = 1'b0; e_addr = 16'h0; e_wdata = 8'h00; q_item = 24'h0;
      if (d_wr && exp_q.size() > 0) q_item = exp_q.pop_front();
      if (d_mrd) begin
        e_rd = 1'b1; e_addr = src_a;
      end else if (d_wr) begin
        e_wr = 1'b1; e_addr = q_item[23:8]; e_wdata = q_item[7:0];
      end else if (p_grant) begin
        e_rd = 1'b1; e_addr = s_p_addr;
      end else if (c_grant) begin
        e_addr = s_c_addr;
        if (c_w) begin
          e_wr = 1'b1; e_wdata = s_c_wdata;
        end else begin
          e_rd = 1'b1;
        end
      end
      chk("dma_active", 24'(dma_active), 24'(act));
      chk("dbg_state_busy", 24'(dbg_dma_state != 2'd0), 24'(act));
      chk("cpu_rdata", 24'(cpu_rdata), 24'(exp_cpu));
      chk("ppu_rdata", 24'(ppu_rdata), 24'(exp_ppu));
      chk("mem_rd", 24'(mem_rd), 24'(e_rd));
      chk("mem_wr", 24'(mem_wr), 24'(e_wr));
      if (e_rd || e_wr) chk("mem_addr", 24'(mem_addr), 24'(e_addr));
      chk("mem_wdata", 24'(mem_wdata), 24'(e_wdata));
      chk("sys_rd", 24'(sys_rd), 24'(d_srd));
      if (d_srd) chk("sys_addr", 24'(sys_addr), 24'(src_a));

      if (k == 0) begin
        src_byte = d_vram ? model_mem[src_a] : sys_byte(src_a);
        exp_q.push_back({16'hFE00 + 16'(bi), src_byte});
      end
      exp_cpu = (c_grant && c_r) ? model_mem[s_c_addr] : 8'hFF;
      exp_ppu = p_grant ? model_mem[s_p_addr] : 8'hFF;
      if (e_wr) model_mem[e_addr] = e_wdata;
      if (dma_on && rel >= BUSY) dma_on = 1'b0;
      if (s_c_wr && s_c_addr == 16'hFF46) begin
        dma_on   = 1'b1;
        dma_t0   = cyc;
        dma_page = (s_c_wdata >= 8'hE0) ? (s_c_wdata - 8'h20) : s_c_wdata;
        exp_q.delete();
      end
    end
    cyc++;
  endtask

  // driver tasks
  function automatic logic [15:0] pick_cpu_addr();
    case ($urandom_range(0, 3))
      0: return 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
      1: return 16'hFE00 + 16'($urandom_range(0, 159));
      2: return 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
      default: begin
        case ($urandom_range(0, 7))
          0: return 16'h7FFF;
          1: return 16'h8000;
          2: return 16'h9FFF;
          3: return 16'hA000;
          4: return 16'hFDFF;
          5: return 16'hFE00;
          6: return 16'hFE9F;
          default: return 16'hFEA0;
        endcase
      end
    endcase
  endfunction

  task automatic set_idle();
    s_rst = 1'b0; s_c_rd = 1'b0; s_c_wr = 1'b0; s_c_addr = 16'h0; s_c_wdata = 8'h0;
    s_mode = 2'd0; s_p_rd = 1'b0; s_p_addr = 16'h0;
  endtask

  task automatic rand_stim();
    int op;
    op        = int'($urandom_range(0, 3));
    s_rst     = 1'b0;
    s_c_rd    = (op == 1) || (op == 3);
    s_c_wr    = (op == 2) || (op == 3);
    s_c_addr  = pick_cpu_addr();
    s_c_wdata = 8'($urandom);
    s_mode    = 2'($urandom_range(0, 3));
    s_p_rd    = 1'($urandom_range(0, 1));
    s_p_addr  = ($urandom_range(0, 1) == 1) ? 16'h8000 + 16'($urandom_range(0, 16'h1FFF))
                                            : 16'hFE00 + 16'($urandom_range(0, 159));
  endtask

  task automatic run_rand(input int n);
    repeat (n) begin
      rand_stim();
      tick();
    end
  endtask

  task automatic dma_write(input logic [7:0] page);
    rand_stim();
    s_c_rd = 1'b0; s_c_wr = 1'b1; s_c_addr = 16'hFF46; s_c_wdata = page;
    tick();
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [7:0] d, input logic [1:0] mode);
    set_idle();
    s_c_rd = rd; s_c_wr = wr; s_c_addr = a; s_c_wdata = d; s_mode = mode;
    tick();
  endtask

  task automatic check_oam_model(input string tag);
    for (int i = 0; i < NBYTES; i++)
      chk(tag, 24'(ram[16'hFE00 + 16'(i)]), 24'(model_mem[16'hFE00 + 16'(i)]));
  endtask

  task automatic check_oam_sys(input string tag, input logic [7:0] page);
    for (int i = 0; i < NBYTES; i++)
      chk(tag, 24'(ram[16'hFE00 + 16'(i)]), 24'(sys_byte({page, 8'(i)})));
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) model_mem[a] = init_byte(16'(a));
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    ppu_mode = 2'd0; ppu_rd = 1'b0; ppu_addr = 16'h0;
    set_idle();
    s_rst = 1'b1;
    repeat (3) tick();
    set_idle();
    tick();

    // VRAM write then read-back in H_BLANK
    cpu_op(1'b0, 1'b1, 16'h8010, 8'h5A, 2'd0);
    cpu_op(1'b1, 1'b0, 16'h8010, 8'h00, 2'd0);
    cpu_op(1'b0, 1'b0, 16'h0000, 8'h00, 2'd0);

    // DRAW: CPU VRAM read and OAM write blocked, PPU fetch still served
    cpu_op(1'b1, 1'b0, 16'h9800, 8'h00, 2'd3);
    cpu_op(1'b0, 1'b1, 16'hFE00, 8'hA5, 2'd3);
    set_idle(); s_mode = 2'd3; s_p_rd = 1'b1; s_p_addr = 16'h9800; tick();
    set_idle(); s_mode = 2'd3; s_c_rd = 1'b1; s_c_addr = 16'h8123;
    s_p_rd = 1'b1; s_p_addr = 16'h9801; tick();
    set_idle(); tick();

    run_rand(300);

    // DMA from system bus page 0xC1
    dma_write(8'hC1);
    run_rand(BUSY);
    set_idle(); repeat (2) tick();
    check_oam_model("oam_c1_model");
    check_oam_sys("oam_c1_src", 8'hC1);

    // DMA from VRAM page 0x80, PPU fetches collide with source reads
    dma_write(8'h80);
    run_rand(BUSY);
    set_idle(); repeat (2) tick();
    check_oam_model("oam_80_model");

    // restart during byte 50 capture clock: in-flight byte dropped
    dma_write(8'hC1);
    run_rand(202);
    dma_write(8'hD2);
    run_rand(BUSY);
    set_idle(); repeat (2) tick();
    check_oam_model("oam_d2_model");
    check_oam_sys("oam_d2_src", 8'hD2);

    // restart coinciding with byte 7 write; 0xE5 mirrors to 0xC5
    dma_write(8'h90);
    run_rand(31);
    dma_write(8'hE5);
    run_rand(BUSY);
    set_idle(); repeat (2) tick();
    check_oam_model("oam_c5_model");
    check_oam_sys("oam_c5_src", 8'hC5);

    // reset at byte 10 aborts the transfer
    dma_write(8'hC3);
    run_rand(41);
    set_idle(); s_rst = 1'b1; tick();
    set_idle(); tick();
    run_rand(60);
    check_oam_model("oam_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
